// File: rtl/ay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ay_pkg
// Purpose  : Shared constants for the AY-3-8910 compatible PSG: register
//            indices, per-register write masks and envelope shape bits.
// Revision : 1.0 - initial release
// ============================================================================
package ay_pkg;

    // Register indices
    localparam logic [3:0] R_TONE_A_L  = 4'd0;
    localparam logic [3:0] R_TONE_A_H  = 4'd1;
    localparam logic [3:0] R_TONE_B_L  = 4'd2;
    localparam logic [3:0] R_TONE_B_H  = 4'd3;
    localparam logic [3:0] R_TONE_C_L  = 4'd4;
    localparam logic [3:0] R_TONE_C_H  = 4'd5;
    localparam logic [3:0] R_NOISE_P   = 4'd6;
    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_AMP_A     = 4'd8;
    localparam logic [3:0] R_AMP_B     = 4'd9;
    localparam logic [3:0] R_AMP_C     = 4'd10;
    localparam logic [3:0] R_ENV_P_L   = 4'd11;
    localparam logic [3:0] R_ENV_P_H   = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IO_A      = 4'd14;
    localparam logic [3:0] R_IO_B      = 4'd15;

    // Envelope shape bit positions inside R13
    localparam int ENV_HOLD = 0;
    localparam int ENV_ALT  = 1;
    localparam int ENV_ATT  = 2;
    localparam int ENV_CONT = 3;

    // Implemented bits of each register; unimplemented bits read back as 0
    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        logic [7:0] m;
        case (idx)
            R_TONE_A_H, R_TONE_B_H, R_TONE_C_H, R_ENV_SHAPE: m = 8'h0F;
            R_NOISE_P, R_AMP_A, R_AMP_B, R_AMP_C:            m = 8'h1F;
            default:                                         m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ay_tone.sv
`default_nettype none
// ============================================================================
// Module   : ay_tone
// Purpose  : One tone channel: 12-bit period counter that toggles the square
//            wave output every TP enable pulses (TP = 0 behaves as 1).
// Revision : 1.0 - initial release
// ============================================================================
module ay_tone (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [11:0] period_i,
    output logic        tone_o
);
    logic [11:0] cnt_q, cnt_d;
    logic        tone_q, tone_d;
    logic [11:0] tp;
    logic [12:0] cnt_inc;

    // Next count/toggle; >= compare makes a shortened period wrap at once
    always_comb begin
        tp      = (period_i == 12'd0) ? 12'd1 : period_i;
        cnt_inc = {1'b0, cnt_q} + 13'd1;
        cnt_d   = cnt_q;
        tone_d  = tone_q;
        if (en_i) begin
            if (cnt_inc >= {1'b0, tp}) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_inc[11:0];
            end
        end
    end

    // Counter and output state
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;
endmodule
`default_nettype wire

// File: rtl/ay_psg.sv
`default_nettype none
// ============================================================================
// Module   : ay_psg
// Purpose  : AY-3-8910 compatible sound generator: 16-register file, three
//            tone channels, noise LFSR, envelope and registered mixer.
// Revision : 1.0 - initial release
// ============================================================================
module ay_psg
    import ay_pkg::*;
#(
    parameter int CLK_DIV = 14
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       addr_we_i,
    input  logic       data_we_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic [3:0] ch_a_o,
    output logic [3:0] ch_b_o,
    output logic [3:0] ch_c_o,
    output logic [5:0] mix_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       pre_q, pre_d;
    logic             tick, tone_en, ns_en;

    // PSG tick every CLK_DIV clocks; prescaler derives tone (/8) and noise (/16) rates
    always_comb begin
        tick    = (div_q == DIV_W'(CLK_DIV - 1));
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        pre_d   = tick ? pre_q + 4'd1 : pre_q;
        tone_en = tick && (pre_q[2:0] == 3'd7);
        ns_en   = tick && (pre_q == 4'd15);
    end

    // Divider and prescaler state
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            div_q <= '0;
            pre_q <= '0;
        end else begin
            div_q <= div_d;
            pre_q <= pre_d;
        end
    end

    // ---------------- register file ----------------
    logic [7:0] regs_q [16];
    logic [3:0] addr_q;
    logic       sel_q;
    logic       reg_wr, env_wr;

    assign reg_wr = data_we_i && sel_q;
    assign env_wr = reg_wr && (addr_q == R_ENV_SHAPE);

    // Data write uses the address latched before any same-cycle address write
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= (i == int'(R_MIXER)) ? 8'hFF : 8'h00;
            end
            addr_q <= '0;
            sel_q  <= 1'b1;
        end else begin
            if (reg_wr) begin
                regs_q[addr_q] <= din_i & reg_mask(addr_q);
            end
            if (addr_we_i) begin
                addr_q <= din_i[3:0];
                sel_q  <= (din_i[7:4] == 4'h0);
            end
        end
    end

    assign dout_o = sel_q ? regs_q[addr_q] : 8'hFF;

    // ---------------- tone channels ----------------
    logic [2:0] tone;

    for (genvar g = 0; g < 3; g++) begin : g_tone
        ay_tone u_tone (
            .clock_i  (clock_i),
            .reset_i  (reset_i),
            .en_i     (tone_en),
            .period_i ({regs_q[2*g+1][3:0], regs_q[2*g]}),
            .tone_o   (tone[g])
        );
    end

    // ---------------- noise ----------------
    logic [4:0]  ncnt_q, ncnt_d;
    logic [16:0] lfsr_q, lfsr_d;
    logic [4:0]  np;
    logic        noise;

    // Noise period counter; the 17-bit LFSR shifts once per NP noise pulses
    always_comb begin
        np     = (regs_q[R_NOISE_P][4:0] == 5'd0) ? 5'd1 : regs_q[R_NOISE_P][4:0];
        ncnt_d = ncnt_q;
        lfsr_d = lfsr_q;
        if (ns_en) begin
            if (({1'b0, ncnt_q} + 6'd1) >= {1'b0, np}) begin
                ncnt_d = '0;
                lfsr_d = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
            end else begin
                ncnt_d = ncnt_q + 5'd1;
            end
        end
    end

    // Noise state
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ncnt_q <= '0;
            lfsr_q <= 17'h1;
        end else begin
            ncnt_q <= ncnt_d;
            lfsr_q <= lfsr_d;
        end
    end

    assign noise = lfsr_q[0];

    // ---------------- envelope ----------------
    logic [15:0] ecnt_q, ecnt_d;
    logic [15:0] ep;
    logic [3:0]  step_q, step_d;
    logic        flip_q, flip_d;
    logic        held_q, held_d;
    logic [3:0]  shape;
    logic [3:0]  env_level;

    // Holding parks step at 15; flip is chosen so the parked level is 0 or 15 as required
    always_comb begin
        shape  = regs_q[R_ENV_SHAPE][3:0];
        ep     = ({regs_q[R_ENV_P_H], regs_q[R_ENV_P_L]} == 16'd0) ? 16'd1
                 : {regs_q[R_ENV_P_H], regs_q[R_ENV_P_L]};
        ecnt_d = ecnt_q;
        step_d = step_q;
        flip_d = flip_q;
        held_d = held_q;
        if (env_wr) begin
            ecnt_d = '0;
            step_d = '0;
            flip_d = 1'b0;
            held_d = 1'b0;
        end else if (ns_en) begin
            if (({1'b0, ecnt_q} + 17'd1) >= {1'b0, ep}) begin
                ecnt_d = '0;
                if (!held_q) begin
                    if (step_q != 4'd15) begin
                        step_d = step_q + 4'd1;
                    end else if (!shape[ENV_CONT]) begin
                        held_d = 1'b1;
                        flip_d = shape[ENV_ATT];
                    end else if (shape[ENV_HOLD]) begin
                        held_d = 1'b1;
                        flip_d = shape[ENV_ALT];
                    end else if (shape[ENV_ALT]) begin
                        step_d = '0;
                        flip_d = ~flip_q;
                    end else begin
                        step_d = '0;
                    end
                end
            end else begin
                ecnt_d = ecnt_q + 16'd1;
            end
        end
        env_level = (shape[ENV_ATT] ^ flip_q) ? step_q : (4'd15 - step_q);
    end

    // Envelope state
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ecnt_q <= '0;
            step_q <= '0;
            flip_q <= 1'b0;
            held_q <= 1'b0;
        end else begin
            ecnt_q <= ecnt_d;
            step_q <= step_d;
            flip_q <= flip_d;
            held_q <= held_d;
        end
    end

    // ---------------- mixer ----------------
    logic [2:0][3:0] ch_q, ch_d;
    logic [5:0]      mix_q;

    // Channel gate combines tone and noise, each forced open by its R7 disable bit
    always_comb begin
        for (int x = 0; x < 3; x++) begin
            if ((tone[x] | regs_q[R_MIXER][x]) & (noise | regs_q[R_MIXER][x+3])) begin
                ch_d[x] = regs_q[int'(R_AMP_A) + x][4] ? env_level
                          : regs_q[int'(R_AMP_A) + x][3:0];
            end else begin
                ch_d[x] = 4'd0;
            end
        end
    end

    // Registered channel levels, then their sum one clock later
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ch_q  <= '0;
            mix_q <= '0;
        end else begin
            ch_q  <= ch_d;
            mix_q <= {2'b00, ch_q[0]} + {2'b00, ch_q[1]} + {2'b00, ch_q[2]};
        end
    end

    assign ch_a_o = ch_q[0];
    assign ch_b_o = ch_q[1];
    assign ch_c_o = ch_q[2];
    assign mix_o  = mix_q;
endmodule
`default_nettype wire
